// File: rtl/acc_proc_core.sv
// Multi-cycle accumulator soft-processor: fetch/decode/execute FSM, internal data RAM, external ROM.
// Define ACC_PROC_SAT_EN for saturating ADD/SUB and the sticky flag_v output.
module acc_proc_core #(
  parameter int DATA_W    = 14,
  parameter int ADDR_W    = 8,
  parameter int RAM_DEPTH = 256,
  parameter int KEY_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key_in,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [ADDR_W+3:0] instr_data,
  output logic [DATA_W-1:0] out,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_n,
  output logic              halted
`ifdef ACC_PROC_SAT_EN
  ,
  output logic              flag_v
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_LDI = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB, OP_JN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD, OP_HALT = 4'hE;

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(RAM_DEPTH);

  state_t                    state, state_nxt;
  logic [ADDR_W+3:0]         ir;
  logic signed [DATA_W-1:0]  acc, acc_nxt, rdata;
  logic                      acc_we, br_taken;
  logic [3:0]                op;
  logic [ADDR_W-1:0]         opnd;
  logic signed [ADDR_W-1:0]  opnd_s;
  logic                      in_range;
  logic [RAM_AW-1:0]         ram_idx;
  logic signed [DATA_W-1:0]  mem [RAM_DEPTH];

`ifdef ACC_PROC_SAT_EN
  logic signed [DATA_W:0]    sum;
  logic                      sat_hit;

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction
`endif

  assign op         = ir[ADDR_W+3:ADDR_W];
  assign opnd       = ir[ADDR_W-1:0];
  assign opnd_s     = opnd;
  assign in_range   = {1'b0, opnd} < DEPTH_L;
  assign ram_idx    = opnd[RAM_AW-1:0];
  assign instr_addr = pc;
  assign flag_z     = (acc == '0);
  assign flag_n     = acc[DATA_W-1];
  assign halted     = (state == S_HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
      default:  state_nxt = S_HALT;
    endcase
  end

  // Execute-stage result; only meaningful while state == S_EXEC
  always_comb begin
    acc_we   = 1'b0;
    acc_nxt  = acc;
    br_taken = 1'b0;
`ifdef ACC_PROC_SAT_EN
    sum      = '0;
    sat_hit  = 1'b0;
`endif
    case (op)
      OP_LDA: begin acc_we = 1'b1; acc_nxt = rdata; end
      OP_ADD, OP_SUB: begin
        acc_we = 1'b1;
`ifdef ACC_PROC_SAT_EN
        if (op == OP_SUB) sum = $signed({acc[DATA_W-1], acc}) - $signed({rdata[DATA_W-1], rdata});
        else              sum = $signed({acc[DATA_W-1], acc}) + $signed({rdata[DATA_W-1], rdata});
        acc_nxt = sat_fn(sum);
        sat_hit = sum[DATA_W] ^ sum[DATA_W-1];
`else
        acc_nxt = (op == OP_SUB) ? acc - rdata : acc + rdata;
`endif
      end
      OP_AND: begin acc_we = 1'b1; acc_nxt = acc & rdata; end
      OP_OR:  begin acc_we = 1'b1; acc_nxt = acc | rdata; end
      OP_XOR: begin acc_we = 1'b1; acc_nxt = acc ^ rdata; end
      OP_LDI: begin acc_we = 1'b1; acc_nxt = DATA_W'(opnd_s); end
      OP_IN:  begin acc_we = 1'b1; acc_nxt = DATA_W'(key_in); end
      OP_JMP: br_taken = 1'b1;
      OP_JZ:  br_taken = flag_z;
      OP_JN:  br_taken = flag_n;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      acc   <= '0;
      out   <= '0;
`ifdef ACC_PROC_SAT_EN
      flag_v <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          ir <= instr_data;
          pc <= pc + ADDR_W'(1);
        end
        S_EXEC: begin
          if (acc_we)        acc <= acc_nxt;
          if (op == OP_OUT)  out <= acc;
          if (br_taken)      pc  <= opnd;
`ifdef ACC_PROC_SAT_EN
          if (op == OP_LDI)  flag_v <= 1'b0;
          else if (sat_hit)  flag_v <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Data RAM: not reset; write is gated by the async-reset state so an aborted STA is lost
  always_ff @(posedge clk) begin
    if (state == S_DECODE)
      rdata <= in_range ? mem[ram_idx] : '0;
    if (state == S_EXEC && op == OP_STA && in_range)
      mem[ram_idx] <= acc;
  end

endmodule
